reservation_station: RTL and testbench

- Tomasulo reservation station that sits directly downstream of bancoRegistradores.
- Accepts issued instructions carrying the register-bank operand values or producer tags.
- Snoops the common data bus (CDB) for missing operands and dispatches operand-complete entries to one functional unit over a valid/ready handshake.
- Entries are freed on dispatch.

---
 rtl/reservation_station_if.sv | 47 ++++
 rtl/reservation_station.sv | 178 +++++++++++++++++
 tb/tb_reservation_station.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/reservation_station_if.sv
// Issue, CDB and dispatch signal bundle for reservation_station.
// master = upstream issue logic / CDB / functional unit side, slave = the station.
interface reservation_station_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int TAG_W  = 3,
    parameter int OP_W   = 3
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              issue_valid;
    logic              issue_ready;
    logic [OP_W-1:0]   issue_op;
    logic [DATA_W-1:0] issue_vj;
    logic [TAG_W-1:0]  issue_qj;
    logic [DATA_W-1:0] issue_vk;
    logic [TAG_W-1:0]  issue_qk;
    logic [TAG_W-1:0]  issue_dest;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              disp_valid;
    logic              disp_ready;
    logic [OP_W-1:0]   disp_op;
    logic [DATA_W-1:0] disp_a;
    logic [DATA_W-1:0] disp_b;
    logic [TAG_W-1:0]  disp_dest;
    logic [CNT_W-1:0]  busy_count;

    modport master (
        output issue_valid, issue_op, issue_vj, issue_qj, issue_vk, issue_qk, issue_dest,
        input  issue_ready,
        output cdb_valid, cdb_tag, cdb_data,
        input  disp_valid, disp_op, disp_a, disp_b, disp_dest,
        output disp_ready,
        input  busy_count
    );

    modport slave (
        input  issue_valid, issue_op, issue_vj, issue_qj, issue_vk, issue_qk, issue_dest,
        output issue_ready,
        input  cdb_valid, cdb_tag, cdb_data,
        output disp_valid, disp_op, disp_a, disp_b, disp_dest,
        input  disp_ready,
        output busy_count
    );
endinterface

// File: rtl/reservation_station.sv
// Tomasulo reservation station: issue, CDB snoop, single-FU dispatch.
// Optional macro RS_AGE_ORDER_EN selects oldest-ready dispatch instead of lowest index.
module reservation_station #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int TAG_W  = 3,
    parameter int OP_W   = 3
) (
    input logic                  clock,
    input logic                  reset,
    reservation_station_if.slave rs
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              busy_reg [DEPTH];
    logic [OP_W-1:0]   op_reg   [DEPTH];
    logic [DATA_W-1:0] vj_reg   [DEPTH];
    logic [TAG_W-1:0]  qj_reg   [DEPTH];
    logic [DATA_W-1:0] vk_reg   [DEPTH];
    logic [TAG_W-1:0]  qk_reg   [DEPTH];
    logic [TAG_W-1:0]  dest_reg [DEPTH];

    logic              busy_next [DEPTH];
    logic [OP_W-1:0]   op_next   [DEPTH];
    logic [DATA_W-1:0] vj_next   [DEPTH];
    logic [TAG_W-1:0]  qj_next   [DEPTH];
    logic [DATA_W-1:0] vk_next   [DEPTH];
    logic [TAG_W-1:0]  qk_next   [DEPTH];
    logic [TAG_W-1:0]  dest_next [DEPTH];

    logic [CNT_W-1:0]  count_reg, count_next;
    logic [DEPTH-1:0]  free_vec, ready_vec;
    logic [IDX_W-1:0]  free_idx, disp_idx;
    logic              disp_any, issue_fire, disp_fire, cdb_live;
    logic              issue_hit_j, issue_hit_k;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign free_vec[gi]  = !busy_reg[gi];
            assign ready_vec[gi] = busy_reg[gi] && (qj_reg[gi] == '0) && (qk_reg[gi] == '0);
        end
    endgenerate

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (free_vec[i]) free_idx = IDX_W'(i);
        end
    end

`ifdef RS_AGE_ORDER_EN
    // Age 0 is the oldest entry; ages of busy entries stay dense 0..count-1.
    logic [IDX_W-1:0] age_reg  [DEPTH];
    logic [IDX_W-1:0] age_next [DEPTH];
    logic [IDX_W-1:0] best_age;
    logic             found;

    always_comb begin
        disp_idx = '0;
        best_age = '1;
        found    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready_vec[i] && (!found || age_reg[i] < best_age)) begin
                found    = 1'b1;
                best_age = age_reg[i];
                disp_idx = IDX_W'(i);
            end
        end
    end
`else
    always_comb begin
        disp_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready_vec[i]) disp_idx = IDX_W'(i);
        end
    end
`endif

    // Dispatch is suppressed during reset so nothing leaves while entries are being discarded.
    assign disp_any    = (|ready_vec) && !reset;
    assign issue_fire  = rs.issue_valid && (|free_vec);
    assign disp_fire   = disp_any && rs.disp_ready;
    assign cdb_live    = rs.cdb_valid && (rs.cdb_tag != '0);
    assign issue_hit_j = cdb_live && (rs.issue_qj == rs.cdb_tag);
    assign issue_hit_k = cdb_live && (rs.issue_qk == rs.cdb_tag);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            busy_next[i] = busy_reg[i];
            op_next[i]   = op_reg[i];
            vj_next[i]   = vj_reg[i];
            qj_next[i]   = qj_reg[i];
            vk_next[i]   = vk_reg[i];
            qk_next[i]   = qk_reg[i];
            dest_next[i] = dest_reg[i];
`ifdef RS_AGE_ORDER_EN
            age_next[i]  = age_reg[i];
            if (disp_fire && busy_reg[i] && (age_reg[i] > age_reg[disp_idx]))
                age_next[i] = age_reg[i] - IDX_W'(1);
`endif
            if (cdb_live && busy_reg[i]) begin
                if (qj_reg[i] == rs.cdb_tag) begin
                    vj_next[i] = rs.cdb_data;
                    qj_next[i] = '0;
                end
                if (qk_reg[i] == rs.cdb_tag) begin
                    vk_next[i] = rs.cdb_data;
                    qk_next[i] = '0;
                end
            end
            if (disp_fire && (disp_idx == IDX_W'(i)))
                busy_next[i] = 1'b0;
            if (issue_fire && (free_idx == IDX_W'(i))) begin
                busy_next[i] = 1'b1;
                op_next[i]   = rs.issue_op;
                vj_next[i]   = issue_hit_j ? rs.cdb_data : rs.issue_vj;
                qj_next[i]   = issue_hit_j ? '0 : rs.issue_qj;
                vk_next[i]   = issue_hit_k ? rs.cdb_data : rs.issue_vk;
                qk_next[i]   = issue_hit_k ? '0 : rs.issue_qk;
                dest_next[i] = rs.issue_dest;
`ifdef RS_AGE_ORDER_EN
                // A same-cycle dispatch shrinks the live set, so the newcomer lands one lower.
                age_next[i]  = IDX_W'(count_reg - CNT_W'(disp_fire));
`endif
            end
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({issue_fire, disp_fire})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                busy_reg[i] <= 1'b0;
                op_reg[i]   <= '0;
                vj_reg[i]   <= '0;
                qj_reg[i]   <= '0;
                vk_reg[i]   <= '0;
                qk_reg[i]   <= '0;
                dest_reg[i] <= '0;
`ifdef RS_AGE_ORDER_EN
                age_reg[i]  <= '0;
`endif
            end
        end else begin
            count_reg <= count_next;
            for (int i = 0; i < DEPTH; i++) begin
                busy_reg[i] <= busy_next[i];
                op_reg[i]   <= op_next[i];
                vj_reg[i]   <= vj_next[i];
                qj_reg[i]   <= qj_next[i];
                vk_reg[i]   <= vk_next[i];
                qk_reg[i]   <= qk_next[i];
                dest_reg[i] <= dest_next[i];
`ifdef RS_AGE_ORDER_EN
                age_reg[i]  <= age_next[i];
`endif
            end
        end
    end

    assign rs.issue_ready = |free_vec;
    assign rs.disp_valid  = disp_any;
    assign rs.disp_op     = disp_any ? op_reg[disp_idx]   : '0;
    assign rs.disp_a      = disp_any ? vj_reg[disp_idx]   : '0;
    assign rs.disp_b      = disp_any ? vk_reg[disp_idx]   : '0;
    assign rs.disp_dest   = disp_any ? dest_reg[disp_idx] : '0;
    assign rs.busy_count  = count_reg;
endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed test-plan steps then random traffic,
// compared every cycle against a slot/sequence-number model of the station.
module tb_reservation_station;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 8;
    localparam int TAG_W  = 3;
    localparam int OP_W   = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    reservation_station_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W)) rs_if ();

    reservation_station #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
        .clock (clock),
        .reset (reset),
        .rs    (rs_if.slave)
    );

    typedef struct {
        bit         v;
        logic [2:0] op;
        logic [7:0] vj;
        logic [2:0] qj;
        logic [7:0] vk;
        logic [2:0] qk;
        logic [2:0] dest;
        int         seq;
    } ent_t;

    ent_t m[DEPTH];
    int   seq_ctr = 0;
    int   total   = 0;
    int   bad     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        int best = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (m[i].v && m[i].qj == 3'd0 && m[i].qk == 3'd0) begin
`ifdef RS_AGE_ORDER_EN
                if (best < 0 || m[i].seq < m[best].seq) best = i;
`else
                if (best < 0) best = i;
`endif
            end
        end
        return best;
    endfunction

    function automatic int first_free();
        for (int i = 0; i < DEPTH; i++) if (!m[i].v) return i;
        return -1;
    endfunction

    function automatic int count_busy();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (m[i].v) n++;
        return n;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m[i].v = 1'b0; m[i].op = '0; m[i].vj = '0; m[i].qj = '0;
            m[i].vk = '0; m[i].qk = '0; m[i].dest = '0; m[i].seq = 0;
        end
    endtask

    // Called just after a falling edge: check outputs, drive inputs, advance model one cycle.
    task automatic step(input bit iv, input logic [2:0] op, input logic [7:0] vj, input logic [2:0] qj,
                        input logic [7:0] vk, input logic [2:0] qk, input logic [2:0] dest,
                        input bit cv, input logic [2:0] ct, input logic [7:0] cd, input bit dr);
        int sel, fr;
        logic [2:0] e_op, e_dest;
        logic [7:0] e_a, e_b;
        bit hj, hk;
        sel = pick();
        fr  = first_free();
        e_op = '0; e_dest = '0; e_a = '0; e_b = '0;
        if (sel >= 0) begin
            e_op = m[sel].op; e_a = m[sel].vj; e_b = m[sel].vk; e_dest = m[sel].dest;
        end
        check("busy_count",  32'(rs_if.busy_count), 32'(count_busy()));
        check("issue_ready", 32'(rs_if.issue_ready), 32'(fr >= 0));
        check("disp_valid",  32'(rs_if.disp_valid), 32'(sel >= 0));
        check("disp_op",     32'(rs_if.disp_op), 32'(e_op));
        check("disp_a",      32'(rs_if.disp_a), 32'(e_a));
        check("disp_b",      32'(rs_if.disp_b), 32'(e_b));
        check("disp_dest",   32'(rs_if.disp_dest), 32'(e_dest));
        $display("cyc iv=%0b q=%0d/%0d dest=%0d cdb=%0b:%0d:%h dr=%0b | disp=%0b dest=%0h a=%h b=%h cnt=%0d",
                 iv, qj, qk, dest, cv, ct, cd, dr, rs_if.disp_valid, rs_if.disp_dest,
                 rs_if.disp_a, rs_if.disp_b, rs_if.busy_count);

        rs_if.issue_valid = iv; rs_if.issue_op = op;
        rs_if.issue_vj = vj; rs_if.issue_qj = qj; rs_if.issue_vk = vk; rs_if.issue_qk = qk;
        rs_if.issue_dest = dest;
        rs_if.cdb_valid = cv; rs_if.cdb_tag = ct; rs_if.cdb_data = cd;
        rs_if.disp_ready = dr;

        if (cv && ct != 3'd0) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (m[i].v && m[i].qj == ct) begin m[i].vj = cd; m[i].qj = 3'd0; end
                if (m[i].v && m[i].qk == ct) begin m[i].vk = cd; m[i].qk = 3'd0; end
            end
        end
        if (sel >= 0 && dr) m[sel].v = 1'b0;
        if (iv && fr >= 0) begin
            hj = cv && ct != 3'd0 && qj == ct;
            hk = cv && ct != 3'd0 && qk == ct;
            m[fr].v = 1'b1; m[fr].op = op; m[fr].dest = dest;
            m[fr].vj = hj ? cd : vj; m[fr].qj = hj ? 3'd0 : qj;
            m[fr].vk = hk ? cd : vk; m[fr].qk = hk ? 3'd0 : qk;
            m[fr].seq = seq_ctr++;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle(input bit dr);
        step(1'b0, 3'd0, 8'd0, 3'd0, 8'd0, 3'd0, 3'd0, 1'b0, 3'd0, 8'd0, dr);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rs_if.issue_valid = 1'b0; rs_if.cdb_valid = 1'b0; rs_if.disp_ready = 1'b1;
        #1;
        check("reset_cycle_disp_valid", 32'(rs_if.disp_valid), 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_clear();
        $display("reset applied");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rs_if.issue_valid = 1'b0; rs_if.issue_op = '0; rs_if.issue_vj = '0; rs_if.issue_qj = '0;
        rs_if.issue_vk = '0; rs_if.issue_qk = '0; rs_if.issue_dest = '0;
        rs_if.cdb_valid = 1'b0; rs_if.cdb_tag = '0; rs_if.cdb_data = '0; rs_if.disp_ready = 1'b0;
        model_clear();
        @(negedge clock);
        do_reset();

        // Ready operands: dispatch the cycle after issue.
        step(1'b1, 3'd2, 8'h05, 3'd0, 8'h03, 3'd0, 3'd1, 1'b0, 3'd0, 8'h00, 1'b1);
        check("tp1_disp_a", 32'(rs_if.disp_a), 32'h05);
        idle(1'b1);
        idle(1'b1);

        // Operand woken by CDB two cycles after issue.
        step(1'b1, 3'd1, 8'h00, 3'd3, 8'h10, 3'd0, 3'd2, 1'b0, 3'd0, 8'h00, 1'b1);
        idle(1'b1);
        idle(1'b1);
        step(1'b0, 3'd0, 8'h00, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1, 3'd3, 8'hAA, 1'b1);
        check("tp2_disp_a", 32'(rs_if.disp_a), 32'hAA);
        idle(1'b1);

        // Same-cycle capture of a broadcast at issue.
        step(1'b1, 3'd4, 8'h00, 3'd5, 8'h22, 3'd0, 3'd3, 1'b1, 3'd5, 8'h7E, 1'b1);
        check("tp3_disp_a", 32'(rs_if.disp_a), 32'h7E);
        idle(1'b1);

        // Fill with the FU stalled, try a fifth issue, then drain.
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 3'(i), 8'(8'h40 + i), 3'd0, 8'(8'h80 + i), 3'd0, 3'(i + 1), 1'b0, 3'd0, 8'h00, 1'b0);
        check("full_issue_ready", 32'(rs_if.issue_ready), 32'd0);
        check("full_busy_count", 32'(rs_if.busy_count), 32'(DEPTH));
        step(1'b1, 3'd7, 8'hEE, 3'd0, 8'hEE, 3'd0, 3'd7, 1'b0, 3'd0, 8'h00, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

        // Age scenario: old 1..3 wait on tag 6, entry 0 leaves and is refilled by a newer waiter.
        step(1'b1, 3'd1, 8'h11, 3'd0, 8'h01, 3'd0, 3'd1, 1'b0, 3'd0, 8'h00, 1'b0);
        for (int i = 1; i < DEPTH; i++)
            step(1'b1, 3'd2, 8'h00, 3'd6, 8'(i), 3'd0, 3'(i + 1), 1'b0, 3'd0, 8'h00, 1'b0);
        idle(1'b1);
        step(1'b1, 3'd3, 8'h00, 3'd6, 8'h55, 3'd0, 3'd5, 1'b0, 3'd0, 8'h00, 1'b1);
        step(1'b0, 3'd0, 8'h00, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1, 3'd6, 8'hC3, 1'b1);
`ifdef RS_AGE_ORDER_EN
        check("age_first_dest", 32'(rs_if.disp_dest), 32'd2);
`else
        check("index_first_dest", 32'(rs_if.disp_dest), 32'd5);
`endif
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

        // Reset with three waiting entries, then a broadcast that must wake nothing.
        for (int i = 0; i < 3; i++)
            step(1'b1, 3'd6, 8'h00, 3'd7, 8'h09, 3'd0, 3'(i + 1), 1'b0, 3'd0, 8'h00, 1'b1);
        do_reset();
        check("post_reset_busy_count", 32'(rs_if.busy_count), 32'd0);
        step(1'b0, 3'd0, 8'h00, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1, 3'd7, 8'h99, 1'b1);
        idle(1'b1);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            logic [2:0] qj, qk;
            qj = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            qk = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            step(1'($urandom_range(0, 9) < 6), 3'($urandom), 8'($urandom), qj, 8'($urandom), qk,
                 3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 8'($urandom), 1'($urandom_range(0, 9) < 7));
            if (n == 300) do_reset();
        end
        for (int i = 0; i < 12; i++)
            step(1'b0, 3'd0, 8'h00, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1, 3'(i % 7 + 1), 8'(i), 1'b1);
        idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
